// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module   : alu_ctrl_pkg
// Brief    : ALU control codes, execution-unit state encoding and result type
//            shared by the ALU controller and the execution unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

    localparam int unsigned C_DATA_W = 32;

    localparam logic [3:0] c_ALU_AND  = 4'd0;
    localparam logic [3:0] c_ALU_OR   = 4'd1;
    localparam logic [3:0] c_ALU_ADD  = 4'd2;
    localparam logic [3:0] c_ALU_SUB  = 4'd3;
    localparam logic [3:0] c_ALU_SLT  = 4'd4;
    localparam logic [3:0] c_ALU_BEQ  = 4'd7;
    localparam logic [3:0] c_ALU_LUI  = 4'd8;
    localparam logic [3:0] c_ALU_ORI  = 4'd9;
    localparam logic [3:0] c_ALU_BNE  = 4'd10;
    localparam logic [3:0] c_ALU_MULT = 4'd11;
    localparam logic [3:0] c_ALU_NOP  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } exec_state_t;

    typedef struct packed {
        logic [C_DATA_W-1:0] result;
        logic                zero;
    } alu_out_t;

endpackage : alu_ctrl_pkg

`default_nettype wire

// File: rtl/mul_iter.sv
// ============================================================================
// Module   : mul_iter
// Brief    : 32-step shift-add multiplier, one multiplier bit per step,
//            low 32 bits of the product only.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_iter
    import alu_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                i_load,
    input  logic                i_step,
    input  logic [C_DATA_W-1:0] i_mcand,
    input  logic [C_DATA_W-1:0] i_mplier,
    output logic [C_DATA_W-1:0] o_product,
    output logic                o_last
);

    logic [C_DATA_W-1:0] r_acc;
    logic [C_DATA_W-1:0] r_mcand;
    logic [C_DATA_W-1:0] r_mplier;
    logic [4:0]          r_cnt;
    logic [C_DATA_W-1:0] w_sum;

    // Accumulator value including the current step, so the final product is
    // available combinationally on the last step without an extra cycle.
    assign w_sum     = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_product = w_sum;
    assign o_last    = (r_cnt == 5'd31);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= 5'd0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_cnt    <= 5'd0;
        end else if (i_step) begin
            r_acc    <= w_sum;
            r_mcand  <= {r_mcand[C_DATA_W-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[C_DATA_W-1:1]};
            r_cnt    <= r_cnt + 5'd1;
        end
    end

endmodule : mul_iter

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module   : alu_exec_unit
// Brief    : ALU execution unit; single-cycle logic/arith ops plus a 32-cycle
//            iterative multiply, with a ready/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_unit
    import alu_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [3:0]          ctrl_i,
    input  logic [C_DATA_W-1:0] src1_i,
    input  logic [C_DATA_W-1:0] src2_i,
    output logic                ready_o,
    output logic                done_o,
    output logic [C_DATA_W-1:0] result_o,
    output logic                zero_o
);

    function automatic alu_out_t alu_compute(input logic [3:0]          ctrl,
                                             input logic [C_DATA_W-1:0] a,
                                             input logic [C_DATA_W-1:0] b);
        alu_out_t o;
        o.result = '0;
        o.zero   = 1'b0;
        case (ctrl)
            c_ALU_AND: o.result = a & b;
            c_ALU_OR,
            c_ALU_ORI: o.result = a | b;
            c_ALU_ADD: o.result = a + b;
            c_ALU_SUB,
            c_ALU_BEQ,
            c_ALU_BNE: o.result = a - b;
            c_ALU_SLT: o.result = {{(C_DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            c_ALU_LUI: o.result = {b[15:0], 16'h0000};
            default:   o.result = '0;
        endcase
        case (ctrl)
            c_ALU_AND, c_ALU_OR, c_ALU_ADD, c_ALU_SUB,
            c_ALU_SLT, c_ALU_LUI, c_ALU_ORI: o.zero = (o.result == '0);
            c_ALU_BEQ:                       o.zero = (a == b);
            c_ALU_BNE:                       o.zero = (a != b);
            default:                         o.zero = 1'b0;
        endcase
        return o;
    endfunction

    exec_state_t         r_state;
    logic                r_ready;
    logic                r_done;
    logic [C_DATA_W-1:0] r_result;
    logic                r_zero;

    logic                w_accept;
    logic                w_mul_load;
    logic                w_mul_step;
    logic                w_mul_last;
    logic [C_DATA_W-1:0] w_mul_product;
    alu_out_t            w_alu;

    assign w_accept   = (r_state == ST_IDLE) && start_i;
    assign w_mul_load = w_accept && (ctrl_i == c_ALU_MULT);
    assign w_mul_step = (r_state == ST_MUL);
    assign w_alu      = alu_compute(ctrl_i, src1_i, src2_i);

    // Operands are latched inside the multiplier on load, so later changes on
    // src1_i/src2_i cannot disturb an in-flight product.
    mul_iter u_mul_iter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_load    (w_mul_load),
        .i_step    (w_mul_step),
        .i_mcand   (src1_i),
        .i_mplier  (src2_i),
        .o_product (w_mul_product),
        .o_last    (w_mul_last)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        if (ctrl_i == c_ALU_MULT) begin
                            r_state <= ST_MUL;
                        end else begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_alu.result;
                            r_zero   <= w_alu.zero;
                        end
                    end
                end
                ST_MUL: begin
                    if (w_mul_last) begin
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_mul_product;
                        r_zero   <= (w_mul_product == '0);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o  = r_ready;
    assign done_o   = r_done;
    assign result_o = r_result;
    assign zero_o   = r_zero;

endmodule : alu_exec_unit

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Directed self-checking bench for alu_exec_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        ready_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        zero_o;

    int checks;
    int failures;

    alu_exec_unit dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .result_o (result_o),
        .zero_o   (zero_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Present one request at a negedge, let the next rising edge accept it.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        start_i = 1'b1;
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i   = 1'b0;
        start_i = 1'b0;
        ctrl_i  = 4'd0;
        src1_i  = '0;
        src2_i  = '0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1 || done_o !== 1'b0 || result_o !== 32'h0 || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ready=%b done=%b result=%h zero=%b, expected 1 0 00000000 0",
                     ready_o, done_o, result_o, zero_o);
        end
    endtask

    // First accept lands on the first rising edge after release.
    task automatic test_add_after_reset;
        @(negedge clk_i);
        rst_i   = 1'b1;
        start_i = 1'b1;
        ctrl_i  = 4'd2;
        src1_i  = 32'h7FFF_FFFF;
        src2_i  = 32'h0000_0001;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 32'h8000_0000 || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL add_wrap: done=%b ready=%b result=%h zero=%b, expected 1 0 80000000 0",
                     done_o, ready_o, result_o, zero_o);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'h8000_0000) begin
            failures++;
            $display("FAIL add_hold: done=%b ready=%b result=%h, expected 0 1 80000000",
                     done_o, ready_o, result_o);
        end
    endtask

    task automatic test_slt_branch;
        issue(4'd4, 32'hFFFF_FFFF, 32'h0000_0001);
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'h1 || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL slt_signed: done=%b result=%h zero=%b, expected 1 00000001 0",
                     done_o, result_o, zero_o);
        end
        issue(4'd7, 32'h0000_1234, 32'h0000_1234);
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'h0 || zero_o !== 1'b1) begin
            failures++;
            $display("FAIL beq_equal: done=%b result=%h zero=%b, expected 1 00000000 1",
                     done_o, result_o, zero_o);
        end
        issue(4'd10, 32'h0000_1234, 32'h0000_1234);
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'h0 || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL bne_equal: done=%b result=%h zero=%b, expected 1 00000000 0",
                     done_o, result_o, zero_o);
        end
        issue(4'd10, 32'h0000_0005, 32'h0000_0003);
        @(negedge clk_i);
        checks++;
        if (result_o !== 32'h2 || zero_o !== 1'b1) begin
            failures++;
            $display("FAIL bne_differ: result=%h zero=%b, expected 00000002 1", result_o, zero_o);
        end
    endtask

    task automatic test_logic_arith;
        issue(4'd0, 32'h0000_00F0, 32'h0000_000F);
        @(negedge clk_i);
        checks++;
        if (result_o !== 32'h0 || zero_o !== 1'b1) begin
            failures++;
            $display("FAIL and_zero: result=%h zero=%b, expected 00000000 1", result_o, zero_o);
        end
        issue(4'd1, 32'hA0A0_0000, 32'h0000_0505);
        @(negedge clk_i);
        checks++;
        if (result_o !== 32'hA0A0_0505 || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL or: result=%h zero=%b, expected a0a00505 0", result_o, zero_o);
        end
        issue(4'd3, 32'h0000_0000, 32'h0000_0001);
        @(negedge clk_i);
        checks++;
        if (result_o !== 32'hFFFF_FFFF || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL sub_wrap: result=%h zero=%b, expected ffffffff 0", result_o, zero_o);
        end
        issue(4'd9, 32'h1200_0000, 32'h0000_0034);
        @(negedge clk_i);
        checks++;
        if (result_o !== 32'h1200_0034 || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL ori: result=%h zero=%b, expected 12000034 0", result_o, zero_o);
        end
    endtask

    task automatic test_lui_nop;
        issue(4'd8, 32'h1111_1111, 32'h0000_ABCD);
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'hABCD_0000 || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL lui: done=%b result=%h zero=%b, expected 1 abcd0000 0",
                     done_o, result_o, zero_o);
        end
        issue(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'h0 || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL nop13: done=%b result=%h zero=%b, expected 1 00000000 0",
                     done_o, result_o, zero_o);
        end
        issue(4'd5, 32'h0000_0001, 32'h0000_0001);
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'h0 || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL nop5: done=%b result=%h zero=%b, expected 1 00000000 0",
                     done_o, result_o, zero_o);
        end
    endtask

    // Multiply with operand churn and stray start pulses while busy.
    task automatic test_mult;
        int cyc;
        int low;
        bit seen;
        cyc  = 0;
        low  = 0;
        seen = 1'b0;
        issue(4'd11, 32'h0001_0003, 32'h0002_0005);
        while (!seen && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
            if (ready_o === 1'b0) low++;
            if (done_o === 1'b1) begin
                seen    = 1'b1;
                start_i = 1'b0;
            end else begin
                start_i = cyc[0];
                ctrl_i  = 4'd2;
                src1_i  = $urandom;
                src2_i  = $urandom;
            end
        end
        start_i = 1'b0;
        checks++;
        if (!seen || cyc != 33) begin
            failures++;
            $display("FAIL mult_latency: done seen=%0d at cycle %0d, expected cycle 33", seen, cyc);
        end
        checks++;
        if (low != 33) begin
            failures++;
            $display("FAIL mult_ready_low: ready low %0d cycles, expected 33", low);
        end
        checks++;
        if (result_o !== 32'h000B_000F || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL mult_result: result=%h zero=%b, expected 000b000f 0", result_o, zero_o);
        end
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1 || done_o !== 1'b0 || result_o !== 32'h000B_000F) begin
            failures++;
            $display("FAIL mult_after: ready=%b done=%b result=%h, expected 1 0 000b000f",
                     ready_o, done_o, result_o);
        end
    endtask

    task automatic test_reset_mid_mul;
        issue(4'd11, 32'h0000_0007, 32'h0000_0009);
        repeat (10) @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_mul_busy: ready=%b, expected 0", ready_o);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || done_o !== 1'b0 || result_o !== 32'h0 || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_mul_reset: ready=%b done=%b result=%h zero=%b, expected 1 0 00000000 0",
                     ready_o, done_o, result_o, zero_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        issue(4'd0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'h0F00_0F00 || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_and: done=%b result=%h zero=%b, expected 1 0f000f00 0",
                     done_o, result_o, zero_o);
        end
        // No late completion from the discarded multiply.
        repeat (35) begin
            @(negedge clk_i);
            if (done_o !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL stale_mul_done: done=%b, expected 0", done_o);
            end
        end
        checks++;
        if (result_o !== 32'h0F00_0F00 || ready_o !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_hold: result=%h ready=%b, expected 0f000f00 1", result_o, ready_o);
        end
    endtask

    task automatic test_back_to_back;
        issue(4'd2, 32'h0000_0010, 32'h0000_0020);
        @(negedge clk_i);
        checks++;
        if (result_o !== 32'h30 || done_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: result=%h done=%b, expected 00000030 1", result_o, done_o);
        end
        issue(4'd3, 32'h0000_0030, 32'h0000_0030);
        @(negedge clk_i);
        checks++;
        if (result_o !== 32'h0 || zero_o !== 1'b1 || done_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: result=%h zero=%b done=%b, expected 00000000 1 1",
                     result_o, zero_o, done_o);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
        test_add_after_reset;
        test_slt_branch;
        test_logic_arith;
        test_lui_nop;
        test_mult;
        test_reset_mid_mul;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_exec_unit

`default_nettype wire
